// File: rtl/ffapuf_pkg.sv
// Shared constants for the FF-arbiter PUF challenge-response sequencer:
// FSM state encoding, LFSR feedback taps and the arbiter clear pulse length.
package ffapuf_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_SAMPLE = 3'd3;
  localparam state_t ST_VOTE   = 3'd4;
  localparam state_t ST_OUT    = 3'd5;

  // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register.
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  localparam int CLEAR_CYC = 2;

endpackage

// File: rtl/ffapuf_lfsr.sv
// Right-shifting Galois LFSR holding the next challenge. Load wins over step;
// the caller is responsible for never loading zero.
module ffapuf_lfsr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] TAPS    = 32'h80200003,
  parameter logic [WIDTH-1:0] RST_VAL = 32'hACE12345
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      lfsr_q <= RST_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/ffapuf_crp_ctrl.sv
// Challenge-response sequencer for the FF-arbiter PUF: repeats each challenge,
// majority-votes the responses and offers the CRP on a valid/ready port.
// Optional FFAPUF_UNSTABLE_FLAG_EN adds resp_unstable (bits that disagreed).
module ffapuf_crp_ctrl
  import ffapuf_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               SETTLE   = 8,
  parameter int               REPEATS  = 5,
  parameter logic [WIDTH-1:0] DEF_SEED = 32'hACE12345
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] puf_C,
  output logic             puf_clear,
  input  logic [WIDTH-1:0] puf_O,
  output logic             busy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_chal,
`ifdef FFAPUF_UNSTABLE_FLAG_EN
  output logic [WIDTH-1:0] resp_unstable,
`endif
  output logic [WIDTH-1:0] resp_data
);

  localparam int CNT_W = $clog2(REPEATS + 1);
  localparam int TMR_W = $clog2(SETTLE + CLEAR_CYC + 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [WIDTH-1:0]   puf_c_q, puf_c_d;
  logic               clear_q, clear_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   chal_q;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   cnt_q [WIDTH];

  logic               lfsr_load;
  logic               lfsr_step;
  logic [WIDTH-1:0]   lfsr_val;
  logic [WIDTH-1:0]   seed_fix;
  logic               cnt_clr;
  logic               cnt_acc;
  logic               vote_en;
  logic [WIDTH-1:0]   vote_bits;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_fix = (seed == '0) ? DEF_SEED : seed;

  ffapuf_lfsr #(
    .WIDTH   (WIDTH),
    .TAPS    (WIDTH'(LFSR_TAPS)),
    .RST_VAL (DEF_SEED)
  ) u_lfsr (
    .clk_i      (clk),
    .clr_i      (clr),
    .load_i     (lfsr_load),
    .load_val_i (seed_fix),
    .step_i     (lfsr_step),
    .value_o    (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    rep_d     = rep_q;
    puf_c_d   = puf_c_q;
    clear_d   = clear_q;
    valid_d   = valid_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    cnt_clr   = 1'b0;
    cnt_acc   = 1'b0;
    vote_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          // A seed loaded in the same cycle is already the challenge.
          puf_c_d = seed_load ? seed_fix : lfsr_val;
          cnt_clr = 1'b1;
          rep_d   = '0;
          tmr_d   = '0;
          clear_d = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (tmr_q == TMR_W'(CLEAR_CYC - 1)) begin
          tmr_d   = '0;
          clear_d = 1'b0;
          state_d = ST_SETTLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE - 1)) begin
          tmr_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        cnt_acc = 1'b1;
        if (rep_q < CNT_W'(REPEATS - 1)) begin
          rep_d   = rep_q + 1'b1;
          clear_d = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_VOTE;
        end
      end
      ST_VOTE: begin
        vote_en = 1'b1;
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (valid_q && resp_ready) begin
          valid_d   = 1'b0;
          lfsr_step = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clear_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      rep_q   <= '0;
      puf_c_q <= '0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rep_q   <= rep_d;
      puf_c_q <= puf_c_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
    end
  end

  // Per-bit count of ones seen across the repeats of one challenge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_acc) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(puf_O[i]);
      end
    end
  end

  always_comb begin
    vote_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vote_bits[i] = (cnt_q[i] > CNT_W'(REPEATS / 2));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      chal_q <= '0;
      data_q <= '0;
    end else if (vote_en) begin
      chal_q <= puf_c_q;
      data_q <= vote_bits;
    end
  end

`ifdef FFAPUF_UNSTABLE_FLAG_EN
  logic [WIDTH-1:0] unst_bits;
  logic [WIDTH-1:0] unst_q;

  // A bit is unstable when the repeats did not all agree.
  always_comb begin
    unst_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unst_bits[i] = (cnt_q[i] != '0) && (cnt_q[i] != CNT_W'(REPEATS));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      unst_q <= '0;
    end else if (vote_en) begin
      unst_q <= unst_bits;
    end
  end

  assign resp_unstable = unst_q;
`endif

  assign puf_C      = puf_c_q;
  assign puf_clear  = clear_q;
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = valid_q;
  assign resp_chal  = chal_q;
  assign resp_data  = data_q;

endmodule

// File: tb/tb_ffapuf_crp_ctrl.sv
// Scoreboard bench for ffapuf_crp_ctrl: a PUF stub replays per-repeat words,
// expectations come from a vote/LFSR reference model.
module tb_ffapuf_crp_ctrl;

  localparam logic [31:0] DEF = 32'hACE12345;
  localparam int          REP = 5;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        seed_load;
  logic [31:0] seed;
  logic [31:0] puf_C;
  logic        puf_clear;
  logic [31:0] puf_O;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_chal;
  logic [31:0] resp_data;
`ifdef FFAPUF_UNSTABLE_FLAG_EN
  logic [31:0] resp_unstable;
`endif

  typedef struct {
    logic [31:0] chal;
    logic [31:0] data;
    logic [31:0] unst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] puf_words [REP];
  int          eval_idx   = -1;
  logic        prev_clear = 1'b0;
  int          checks     = 0;
  int          errors     = 0;
  int          hs_count   = 0;
  logic [31:0] model_lfsr = DEF;
  logic        hold_prev  = 1'b0;
  logic [31:0] held_chal;
  logic [31:0] held_data;

  always #5 clk = ~clk;

  ffapuf_crp_ctrl #(
    .WIDTH    (32),
    .SETTLE   (8),
    .REPEATS  (REP),
    .DEF_SEED (DEF)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .seed_load     (seed_load),
    .seed          (seed),
    .puf_C         (puf_C),
    .puf_clear     (puf_clear),
    .puf_O         (puf_O),
    .busy          (busy),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_chal     (resp_chal),
`ifdef FFAPUF_UNSTABLE_FLAG_EN
    .resp_unstable (resp_unstable),
`endif
    .resp_data     (resp_data)
  );

  // PUF stub: each rising clear starts the next evaluation word.
  assign puf_O = (eval_idx >= 0 && eval_idx < REP) ? puf_words[eval_idx] : 32'h0;

  always @(negedge clk) begin
    if (start && !busy) eval_idx = -1;
    if (puf_clear && !prev_clear) eval_idx = eval_idx + 1;
    prev_clear = puf_clear;
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] sh;
    sh = v >> 1;
    return v[0] ? (sh ^ 32'h80200003) : sh;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  always @(negedge clk) begin
    if (clr) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", resp_valid, 1);
        check("hold_chal", resp_chal, held_chal);
        check("hold_data", resp_data, held_data);
      end
      if (resp_valid && resp_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_crp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("crp_chal", resp_chal, e.chal);
          check("crp_data", resp_data, e.data);
`ifdef FFAPUF_UNSTABLE_FLAG_EN
          check("crp_unstable", resp_unstable, e.unst);
`endif
        end
        model_lfsr = lfsr_next(model_lfsr);
      end
      hold_prev = resp_valid && !resp_ready;
      held_chal = resp_chal;
      held_data = resp_data;
    end
  end

  task automatic issue_start(input bit do_load, input logic [31:0] s);
    exp_t e;
    int   c;
    if (do_load) model_lfsr = (s == 32'h0) ? DEF : s;
    e.chal = model_lfsr;
    e.data = '0;
    e.unst = '0;
    for (int b = 0; b < 32; b++) begin
      c = 0;
      for (int r = 0; r < REP; r++) c += int'(puf_words[r][b]);
      e.data[b] = (2 * c > REP);
      e.unst[b] = (c != 0) && (c != REP);
    end
    exp_q.push_back(e);
    start     = 1'b1;
    seed_load = do_load;
    seed      = s;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    check("chal_drive", puf_C, e.chal);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (resp_valid) break;
    end
  endtask

  task automatic finish_crp(input bit rand_ready);
    int n;
    n = 0;
    while (n < 600) begin
      resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
      if (!busy) break;
    end
    check("crp_done", busy, 0);
  endtask

  task automatic rand_words();
    logic [31:0] base;
    base = $urandom;
    for (int r = 0; r < REP; r++) puf_words[r] = base ^ ($urandom & $urandom & $urandom);
  endtask

  initial begin
    int          n;
    int          hs0;
    logic [31:0] s;
    clr = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; resp_ready = 1'b1;
    for (int r = 0; r < REP; r++) puf_words[r] = 32'h0;
    tick(); tick();
    check("rst_puf_C", puf_C, 0);
    check("rst_puf_clear", puf_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_chal", resp_chal, 0);
    check("rst_data", resp_data, 0);
    clr = 1'b0;
    tick();

    // Constant response, default seed, latency.
    for (int r = 0; r < REP; r++) puf_words[r] = 32'h5A5A5A5A;
    issue_start(1'b0, 32'h0);
    check("t1_chal_const", puf_C, 32'hACE12345);
    wait_valid(n);
    check("t1_latency", n, 56);
    check("t1_data_const", resp_data, 32'h5A5A5A5A);
    finish_crp(1'b0);

    // bit0 toggling 1,0,1,0,1 across repeats.
    for (int r = 0; r < REP; r++) puf_words[r] = (r % 2 == 0) ? 32'h5A5A5A5B : 32'h5A5A5A5A;
    issue_start(1'b0, 32'h0);
    wait_valid(n);
    check("t2_data_bit0", resp_data, 32'h5A5A5A5B);
`ifdef FFAPUF_UNSTABLE_FLAG_EN
    check("t2_unstable", resp_unstable, 32'h1);
`endif
    finish_crp(1'b0);

    // Backpressure: 10 cycles without ready.
    rand_words();
    resp_ready = 1'b0;
    issue_start(1'b0, 32'h0);
    wait_valid(n);
    check("t3_latency", n, 56);
    for (int k = 0; k < 10; k++) tick();
    check("t3_still_busy", busy, 1);
    finish_crp(1'b0);
    rand_words();
    issue_start(1'b0, 32'h0);
    finish_crp(1'b0);

    // Seed handling: zero seed maps to default, seed 1 steps to the taps.
    rand_words();
    issue_start(1'b1, 32'h0);
    check("t4_zero_seed", puf_C, 32'hACE12345);
    finish_crp(1'b0);
    seed_load = 1'b1; seed = 32'h1;
    tick();
    seed_load = 1'b0;
    model_lfsr = 32'h1;
    rand_words();
    issue_start(1'b0, 32'h0);
    check("t4_seed_one", puf_C, 32'h1);
    finish_crp(1'b0);
    rand_words();
    issue_start(1'b0, 32'h0);
    check("t4_after_one", puf_C, 32'h80200003);
    finish_crp(1'b0);

    // Reset during SETTLE of the third repeat.
    rand_words();
    issue_start(1'b0, 32'h0);
    n = 0;
    while (n < 200 && !(eval_idx == 2 && busy && !puf_clear)) begin
      tick();
      n++;
    end
    check("t5_reached_settle", (n < 200), 1);
    clr = 1'b1;
    #1;
    check("t5_puf_C", puf_C, 0);
    check("t5_busy", busy, 0);
    check("t5_clear", puf_clear, 0);
    check("t5_valid", resp_valid, 0);
    check("t5_chal", resp_chal, 0);
    check("t5_data", resp_data, 0);
    void'(exp_q.pop_back());
    model_lfsr = DEF;
    tick();
    clr = 1'b0;
    tick();
    rand_words();
    issue_start(1'b0, 32'h0);
    check("t5_restart_chal", puf_C, 32'hACE12345);
    wait_valid(n);
    check("t5_latency", n, 56);
    finish_crp(1'b0);

    // start while busy is ignored.
    hs0 = hs_count;
    rand_words();
    issue_start(1'b0, 32'h0);
    for (int k = 0; k < 10; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_crp(1'b0);
    for (int k = 0; k < 70; k++) tick();
    check("t6_one_crp", hs_count - hs0, 1);
    check("t6_idle", busy, 0);

    // Randomized CRPs with random backpressure and seed reloads.
    for (int t = 0; t < 12; t++) begin
      rand_words();
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      issue_start($urandom_range(0, 3) == 0, s);
      finish_crp(1'b1);
    end

    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
